imem_fetch: RTL
===============

IMEM_FETCH -- requirements
Module: imem_fetch

Interface
REQ-001 Parameter TIMEOUT, default 16, max WAIT/DISCARD cycles without mem_ack before fault; legal range 1..255.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 pc_addr  input  16  instruction address from program counter.
REQ-005 fetch_req  input  1  request fetch of pc_addr; sampled only in IDLE.
REQ-006 flush  input  1  cancel current/pending fetch (branch or PC reload).
REQ-007 fault_clr  input  1  clears sticky fault.
REQ-008 mem_req  output  1  memory read request, level.
REQ-009 mem_addr  output  16  memory read address.
REQ-010 mem_rdata  input  16  memory read data, valid when mem_ack=1.
REQ-011 mem_ack  input  1  memory completion strobe, one cycle.
REQ-012 instr  output  16  last captured instruction word.
REQ-013 instr_valid  output  1  one-cycle pulse: new word on instr.
REQ-014 busy  output  1  high in WAIT or DISCARD.
REQ-015 fault  output  1  sticky timeout flag.

Function
REQ-016 FSM states SHALL be IDLE, WAIT, DISCARD; encoding free.
REQ-017 IDLE, fetch_req=1, flush=0: latch pc_addr into mem_addr, set mem_req=1, clear timeout counter, go WAIT (mem_req visible cycle after request).
REQ-018 IDLE, fetch_req=1 and flush=1 same cycle: flush wins, no fetch, stay IDLE.
REQ-019 fetch_req SHALL be ignored in WAIT and DISCARD; no queuing.
REQ-020 mem_req SHALL stay high and mem_addr stable from WAIT entry until the cycle mem_ack is sampled high or timeout fires (no withdrawal).
REQ-021 WAIT, mem_ack=1, flush=0: capture mem_rdata into instr, pulse instr_valid next cycle for exactly one cycle, drop mem_req, go IDLE.
REQ-022 WAIT, flush=1 without mem_ack: go DISCARD; mem_req stays high.
REQ-023 WAIT, flush=1 and mem_ack=1 same cycle: data discarded, instr unchanged, no instr_valid, drop mem_req, go IDLE.
REQ-024 DISCARD, mem_ack=1: data discarded, drop mem_req, go IDLE; no instr_valid.
REQ-025 flush in DISCARD SHALL have no further effect.
REQ-026 8-bit timeout counter SHALL increment each cycle in WAIT/DISCARD without mem_ack, cleared on WAIT entry.
REQ-027 Counter reaching TIMEOUT without mem_ack: set fault=1, drop mem_req, go IDLE, instr unchanged, no instr_valid.
REQ-028 mem_ack in cycle counter reaches TIMEOUT: ack wins, no fault.
REQ-029 mem_ack in IDLE SHALL be ignored.
REQ-030 fault stays set until fault_clr=1 or reset; fault_clr and new timeout same cycle: fault stays 1.
REQ-031 fault SHALL NOT block new fetches.
REQ-032 instr holds value between captures; back-to-back fetch: fetch_req in the instr_valid cycle accepted (IDLE).
REQ-033 busy = (state != IDLE), registered-state derived, no combinational path from inputs.

Reset
REQ-034 reset=0 SHALL immediately force IDLE, mem_req=0, mem_addr=0, instr=0, instr_valid=0, busy=0, fault=0, counter=0.
REQ-035 reset asserted mid-WAIT: request abandoned; ack after reset release treated as IDLE ack (ignored).
REQ-036 First fetch_req accepted on first rising edge with reset=1.

Verification
REQ-037 pc_addr=0x0040, fetch_req 1 cycle, mem_ack 3 cycles later with rdata=0xA5C3 -> mem_addr=0x0040 held, instr=0xA5C3, one instr_valid pulse, busy low after.
REQ-038 fetch, flush 1 cycle later, ack 2 cycles later rdata=0x1111 -> DISCARD visited, instr keeps prior value, no instr_valid, mem_req held until ack.
REQ-039 TIMEOUT=4, fetch, no ack -> mem_req drops after 4 WAIT cycles, fault=1 sticky; fault_clr -> fault=0; next fetch with ack succeeds.
REQ-040 ack in exact timeout cycle (TIMEOUT=4) -> instr captured, fault stays 0.
REQ-041 fetch_req+flush same IDLE cycle -> mem_req never rises; flush+ack same WAIT cycle -> IDLE, no instr_valid.
REQ-042 reset pulse mid-WAIT, then stale ack -> all outputs 0, ack ignored, next fetch_req normal.

Source files
------------

// File: rtl/imem_fetch.sv
// imem_fetch: single-outstanding instruction fetch unit.
//
// Accepts a fetch request from the program counter while idle and issues a
// level memory read request. It then waits for a one-cycle completion strobe
// and captures the returned word. A flush abandons the fetch in progress.
// The request stays on the bus until the memory answers, and the answer is
// thrown away. A fetch that gets no answer within TIMEOUT cycles is dropped
// and raises a sticky fault flag.
//
// Parameters
//   TIMEOUT      cycles in WAIT/DISCARD without mem_ack before fault (1..255)
// Ports
//   clk          clock, rising edge
//   reset        asynchronous, active-low reset
//   pc_addr      [15:0] instruction address from the program counter
//   fetch_req    fetch pc_addr (sampled only when idle)
//   flush        cancel current/pending fetch
//   fault_clr    clear the sticky fault flag
//   mem_req      memory read request (level)
//   mem_addr     [15:0] memory read address
//   mem_rdata    [15:0] memory read data, valid with mem_ack
//   mem_ack      memory completion strobe
//   instr        [15:0] last captured instruction word
//   instr_valid  one-cycle pulse when instr is updated
//   busy         fetch in flight (WAIT or DISCARD)
//   fault        sticky timeout flag
module imem_fetch #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] pc_addr,
    input  logic        fetch_req,
    input  logic        flush,
    input  logic        fault_clr,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic [15:0] instr,
    output logic        instr_valid,
    output logic        busy,
    output logic        fault
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DISCARD
    } state_t;

    // The timeout fires on the edge where the counter would step up to
    // TIMEOUT, so a request is held for exactly TIMEOUT cycles.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_next;
    logic [7:0]  cnt;
    logic [7:0]  cnt_next;
    logic [15:0] addr_next;
    logic [15:0] instr_next;
    logic        valid_next;
    logic        fault_next;
    logic        timeout_hit;

    assign timeout_hit = (cnt == TIMEOUT_LAST);

    // Both outputs come straight from the state register.
    assign busy    = (state != IDLE);
    assign mem_req = busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            mem_addr    <= 16'd0;
            instr       <= 16'd0;
            instr_valid <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            mem_addr    <= addr_next;
            instr       <= instr_next;
            instr_valid <= valid_next;
            fault       <= fault_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        addr_next  = mem_addr;
        instr_next = instr;
        valid_next = 1'b0;
        // A timeout below overrides a simultaneous fault_clr.
        fault_next = fault_clr ? 1'b0 : fault;

        case (state)
            IDLE: begin
                if (fetch_req && !flush) begin
                    addr_next  = pc_addr;
                    cnt_next   = 8'd0;
                    state_next = WAIT;
                end
            end

            WAIT: begin
                // Ack beats both timeout and flush; flush with ack only
                // suppresses the capture.
                if (mem_ack) begin
                    state_next = IDLE;
                    if (!flush) begin
                        instr_next = mem_rdata;
                        valid_next = 1'b1;
                    end
                end else if (timeout_hit) begin
                    cnt_next   = cnt + 8'd1;
                    fault_next = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + 8'd1;
                    if (flush) begin
                        state_next = DISCARD;
                    end
                end
            end

            DISCARD: begin
                // The request keeps running until the memory answers; the
                // counter carries on from WAIT, it is not restarted.
                if (mem_ack) begin
                    state_next = IDLE;
                end else if (timeout_hit) begin
                    cnt_next   = cnt + 8'd1;
                    fault_next = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
